// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM state type and default width for the sequential ALU.
package alu_seq_pkg;
  localparam int ALU_SEQ_WIDTH = 32;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;
  localparam logic [3:0] ALU_MUL  = 4'b1010;
  localparam logic [3:0] ALU_MULH = 4'b1011;
  localparam logic [3:0] ALU_DIV  = 4'b1100;
  localparam logic [3:0] ALU_REM  = 4'b1101;

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_DONE} state_t;
endpackage

// File: rtl/alu_seq_div.sv
// Restoring unsigned divider on magnitudes, one quotient bit per clock (ALU_SEQ_DIV_EN builds only).
// o_quot/o_rem carry the value being produced this cycle, so they are final while o_valid is high.
`ifdef ALU_SEQ_DIV_EN
module alu_seq_div #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_quot,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_valid
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] r_rem, r_quot, r_dvs;
  logic [CW-1:0]    r_cnt;
  logic             r_act;
  logic [WIDTH:0]   w_shift, w_diff;
  logic             w_fit;

  // divisor magnitude never exceeds 2^(WIDTH-1), so the shifted remainder fits WIDTH+1 bits
  assign w_shift = {r_rem, r_quot[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, r_dvs};
  assign w_fit   = ~w_diff[WIDTH];
  assign o_quot  = {r_quot[WIDTH-2:0], w_fit};
  assign o_rem   = w_fit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign o_valid = r_act && (r_cnt == CW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem  <= '0;
      r_quot <= '0;
      r_dvs  <= '0;
      r_cnt  <= '0;
      r_act  <= 1'b0;
    end else if (i_start) begin
      r_rem  <= '0;
      r_quot <= i_dividend;
      r_dvs  <= i_divisor;
      r_cnt  <= CW'(WIDTH);
      r_act  <= 1'b1;
    end else if (r_act) begin
      r_rem  <= o_rem;
      r_quot <= o_quot;
      r_cnt  <= r_cnt - CW'(1);
      if (r_cnt == CW'(1)) r_act <= 1'b0;
    end
  end
endmodule
`endif

// File: rtl/alu_seq.sv
// Registered ALU with iterative mul/mulh and optional signed div/rem behind Start/Busy/Done.
// Divider present only when ALU_SEQ_DIV_EN is defined; otherwise div/rem return 0 in one cycle.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = ALU_SEQ_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [3:0]       ALUControl,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero,
  output logic             Busy,
  output logic             Done
);
  // states: IDLE wait Start | MUL shift-add | DIV divider running | DONE Done pulse
  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = $clog2(WIDTH + 1);

  state_t             r_state, w_state_nxt;
  logic [3:0]         r_op;
  logic               r_sign;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_mcand, r_res;
  logic [2*WIDTH-1:0] r_acc;
  logic               r_zero;

  logic [WIDTH-1:0]   w_single, w_mag_a, w_mag_b, w_mul_res, w_div_res;
  logic [SHW-1:0]     w_shamt;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_acc_nxt, w_prod;
  logic               w_is_mul, w_is_div, w_div_valid, w_accept;

  assign w_shamt  = SrcB[SHW-1:0];
  assign w_mag_a  = SrcA[WIDTH-1] ? -SrcA : SrcA;
  assign w_mag_b  = SrcB[WIDTH-1] ? -SrcB : SrcB;
  assign w_is_mul = (ALUControl == ALU_MUL) || (ALUControl == ALU_MULH);
  assign w_accept = (r_state == ST_IDLE) && Start;

  always_comb begin
    w_single = '0;
    case (ALUControl)
      ALU_ADD:  w_single = SrcA + SrcB;
      ALU_SUB:  w_single = SrcA - SrcB;
      ALU_AND:  w_single = SrcA & SrcB;
      ALU_OR:   w_single = SrcA | SrcB;
      ALU_XOR:  w_single = SrcA ^ SrcB;
      ALU_SLT:  w_single = {{(WIDTH-1){1'b0}}, $signed(SrcA) < $signed(SrcB)};
      ALU_SLTU: w_single = {{(WIDTH-1){1'b0}}, SrcA < SrcB};
      ALU_SRA:  w_single = $signed(SrcA) >>> w_shamt;
      ALU_SRL:  w_single = SrcA >> w_shamt;
      ALU_SLL:  w_single = SrcA << w_shamt;
      default:  w_single = '0;
    endcase
  end

  // multiplier lives in the low half of the accumulator and shifts out as product bits shift in
  assign w_sum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_mcand} : '0);
  assign w_acc_nxt = {w_sum, r_acc[WIDTH-1:1]};
  assign w_prod    = r_sign ? -w_acc_nxt : w_acc_nxt;
  assign w_mul_res = (r_op == ALU_MULH) ? w_prod[2*WIDTH-1:WIDTH] : w_prod[WIDTH-1:0];

`ifdef ALU_SEQ_DIV_EN
  logic             r_sign_a, r_div0;
  logic [WIDTH-1:0] r_src_a, w_quot_mag, w_rem_mag, w_quot, w_rem;
  logic             w_div_start;

  assign w_is_div    = (ALUControl == ALU_DIV) || (ALUControl == ALU_REM);
  assign w_div_start = w_accept && w_is_div;

  alu_seq_div #(.WIDTH(WIDTH)) u_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (w_div_start),
    .i_dividend (w_mag_a),
    .i_divisor  (w_mag_b),
    .o_quot     (w_quot_mag),
    .o_rem      (w_rem_mag),
    .o_valid    (w_div_valid)
  );

  assign w_quot    = r_div0 ? '1 : (r_sign ? -w_quot_mag : w_quot_mag);
  assign w_rem     = r_div0 ? r_src_a : (r_sign_a ? -w_rem_mag : w_rem_mag);
  assign w_div_res = (r_op == ALU_REM) ? w_rem : w_quot;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sign_a <= 1'b0;
      r_div0   <= 1'b0;
      r_src_a  <= '0;
    end else if (w_div_start) begin
      r_sign_a <= SrcA[WIDTH-1];
      r_div0   <= (SrcB == '0);
      r_src_a  <= SrcA;
    end
  end
`else
  assign w_is_div    = 1'b0;
  assign w_div_valid = 1'b0;
  assign w_div_res   = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (Start) begin
        if (w_is_mul)      w_state_nxt = ST_MUL;
        else if (w_is_div) w_state_nxt = ST_DIV;
        else               w_state_nxt = ST_DONE;
      end
      ST_MUL:  if (r_cnt == CW'(1)) w_state_nxt = ST_DONE;
      ST_DIV:  if (w_div_valid)     w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op    <= '0;
      r_sign  <= 1'b0;
      r_cnt   <= '0;
      r_mcand <= '0;
      r_acc   <= '0;
      r_res   <= '0;
      r_zero  <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: if (Start) begin
          r_op   <= ALUControl;
          r_sign <= SrcA[WIDTH-1] ^ SrcB[WIDTH-1];
          if (w_is_mul) begin
            r_mcand <= w_mag_a;
            r_acc   <= {{WIDTH{1'b0}}, w_mag_b};
            r_cnt   <= CW'(WIDTH);
          end else if (!w_is_div) begin
            r_res  <= w_single;
            r_zero <= (w_single == '0);
          end
        end
        ST_MUL: begin
          r_acc <= w_acc_nxt;
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_res  <= w_mul_res;
            r_zero <= (w_mul_res == '0);
          end
        end
        ST_DIV: if (w_div_valid) begin
          r_res  <= w_div_res;
          r_zero <= (w_div_res == '0);
        end
        default: ;
      endcase
    end
  end

  assign ALUResult = r_res;
  assign Zero      = r_zero;
  assign Busy      = (r_state != ST_IDLE);
  assign Done      = (r_state == ST_DONE);
endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed vector table, random ops vs reference model, handshake and abort.
`timescale 1ns/1ps
module tb_alu_seq;
  import alu_seq_pkg::*;

  localparam int W = 32;
`ifdef ALU_SEQ_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif
  localparam int DIV_LAT = DIV_EN ? 33 : 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         Start = 1'b0;
  logic [W-1:0] SrcA = '0;
  logic [W-1:0] SrcB = '0;
  logic [3:0]   ALUControl = '0;
  logic [W-1:0] ALUResult;
  logic         Zero, Busy, Done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .Start      (Start),
    .SrcA       (SrcA),
    .SrcB       (SrcB),
    .ALUControl (ALUControl),
    .ALUResult  (ALUResult),
    .Zero       (Zero),
    .Busy       (Busy),
    .Done       (Done)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // reference: RISC-V semantics from plain 64-bit arithmetic
  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, sq;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_XOR:  return a ^ b;
      ALU_SLT:  return (sa < sb) ? 32'd1 : 32'd0;
      ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
      ALU_SRA:  return 32'(sa >>> b[4:0]);
      ALU_SRL:  return a >> b[4:0];
      ALU_SLL:  return a << b[4:0];
      ALU_MUL: begin
        p = 64'(a) * 64'(b);
        return p[31:0];
      end
      ALU_MULH: begin
        p = 64'(sa * sb);
        return p[63:32];
      end
      ALU_DIV: begin
        if (!DIV_EN) return 32'd0;
        if (b == 32'd0) return 32'hFFFF_FFFF;
        sq = sa / sb;
        return 32'(sq);
      end
      ALU_REM: begin
        if (!DIV_EN) return 32'd0;
        if (b == 32'd0) return a;
        sq = sa % sb;
        return 32'(sq);
      end
      default: return 32'd0;
    endcase
  endfunction

  function automatic int lat_model(input logic [3:0] op);
    if (op == ALU_MUL || op == ALU_MULH) return 33;
    if (op == ALU_DIV || op == ALU_REM)  return DIV_LAT;
    return 1;
  endfunction

  function automatic logic [31:0] rand_operand();
    logic [31:0] sp [5];
    sp = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic busy_ok);
    @(negedge clk);
    ALUControl = op;
    SrcA       = a;
    SrcB       = b;
    Start      = 1'b1;
    lat        = 0;
    busy_ok    = 1'b1;
    do begin
      @(negedge clk);
      Start = 1'b0;
      lat++;
      if (!Busy) busy_ok = 1'b0;
    end while (!Done && lat < 100);
  endtask

  initial begin
    int          lat;
    logic        busy_ok;
    logic        done_seen;
    logic        held;
    logic [31:0] prev, exp, ra, rb;
    logic [3:0]  rop;

    rst_n = 1'b0;
    Start = 1'b1;
    ALUControl = ALU_ADD;
    SrcA = 32'd5;
    SrcB = 32'd7;
    done_seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (Done) done_seen = 1'b1;
    end
    chk("rst_result", ALUResult, 32'd0);
    chk("rst_zero", Zero, 1);
    chk("rst_busy", Busy, 0);
    chk("rst_done_seen", done_seen, 0);
    Start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    vecs.push_back('{ALU_SUB,  32'd5,        32'd5,        32'd0,        1});
    vecs.push_back('{ALU_SRA,  32'h8000_0000, 32'd4,       32'hF800_0000, 1});
    vecs.push_back('{ALU_SRL,  32'h8000_0000, 32'd4,       32'h0800_0000, 1});
    vecs.push_back('{ALU_SLL,  32'd1,        32'h25,       32'h0000_0020, 1});
    vecs.push_back('{ALU_SLTU, 32'd1,        32'hFFFF_FFFF, 32'd1,        1});
    vecs.push_back('{ALU_SLT,  32'd1,        32'hFFFF_FFFF, 32'd0,        1});
    vecs.push_back('{ALU_ADD,  32'h7FFF_FFFF, 32'd1,       32'h8000_0000, 1});
    vecs.push_back('{ALU_XOR,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1});
    vecs.push_back('{ALU_AND,  32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, 1});
    vecs.push_back('{ALU_OR,   32'hFF00_FF00, 32'h0F0F_0F0F, 32'hFF0F_FF0F, 1});
    vecs.push_back('{4'b1110,  32'd1,        32'd2,        32'd0,        1});
    vecs.push_back('{ALU_MUL,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33});
    vecs.push_back('{ALU_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33});
    vecs.push_back('{ALU_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33});
    vecs.push_back('{ALU_MUL,  32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 33});
    vecs.push_back('{ALU_MULH, 32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 33});
    vecs.push_back('{ALU_DIV,  32'hFFFF_FFF9, 32'd2, DIV_EN ? 32'hFFFF_FFFD : 32'd0, DIV_LAT});
    vecs.push_back('{ALU_REM,  32'hFFFF_FFF9, 32'd2, DIV_EN ? 32'hFFFF_FFFF : 32'd0, DIV_LAT});
    vecs.push_back('{ALU_DIV,  32'd9, 32'd0, DIV_EN ? 32'hFFFF_FFFF : 32'd0, DIV_LAT});
    vecs.push_back('{ALU_REM,  32'd9, 32'd0, DIV_EN ? 32'd9 : 32'd0, DIV_LAT});
    vecs.push_back('{ALU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, DIV_EN ? 32'h8000_0000 : 32'd0, DIV_LAT});
    vecs.push_back('{ALU_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, DIV_LAT});

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, busy_ok);
      chk($sformatf("vec%0d_result", i), ALUResult, vecs[i].exp);
      chk($sformatf("vec%0d_zero", i), Zero, vecs[i].exp == 32'd0);
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("vec%0d_busy", i), busy_ok, 1);
      @(negedge clk);
      chk($sformatf("vec%0d_done_pulse", i), Done, 0);
    end

    for (int n = 0; n < 60; n++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = rand_operand();
      rb  = rand_operand();
      exp = model(rop, ra, rb);
      run_op(rop, ra, rb, lat, busy_ok);
      chk($sformatf("rnd%0d_op%0d_result", n, rop), ALUResult, exp);
      chk($sformatf("rnd%0d_zero", n), Zero, exp == 32'd0);
      chk($sformatf("rnd%0d_latency", n), lat, lat_model(rop));
    end

    // Start held high with changing operands for the whole multiply
    @(negedge clk);
    prev = ALUResult;
    exp  = model(ALU_MUL, 32'h1234_5678, 32'h9ABC_DEF1);
    ALUControl = ALU_MUL;
    SrcA  = 32'h1234_5678;
    SrcB  = 32'h9ABC_DEF1;
    Start = 1'b1;
    lat   = 0;
    held  = 1'b1;
    do begin
      @(negedge clk);
      lat++;
      if (!Done && ALUResult !== prev) held = 1'b0;
      SrcA = $urandom;
      SrcB = $urandom;
      ALUControl = 4'($urandom_range(0, 15));
    end while (!Done && lat < 100);
    Start = 1'b0;
    chk("hs_result", ALUResult, exp);
    chk("hs_latency", lat, 33);
    chk("hs_result_held", held, 1);
    @(negedge clk);
    chk("hs_no_reissue", Busy, 0);

    // asynchronous abort 10 cycles into a long operation
    @(negedge clk);
    ALUControl = DIV_EN ? ALU_DIV : ALU_MUL;
    SrcA  = 32'hFFFF_FFF9;
    SrcB  = 32'd2;
    Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    repeat (9) @(negedge clk);
    chk("abort_busy_before", Busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_result", ALUResult, 32'd0);
    chk("abort_zero", Zero, 1);
    chk("abort_busy", Busy, 0);
    chk("abort_done", Done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (Done || Busy) done_seen = 1'b1;
    end
    chk("abort_quiet", done_seen, 0);
    run_op(ALU_ADD, 32'd2, 32'd3, lat, busy_ok);
    chk("post_abort_add", ALUResult, 32'd5);
    chk("post_abort_latency", lat, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered ALU for the RISC-V datapath: the successor to the single-cycle 32-bit ALU. It widens the operation set to 4-bit `ALUControl`, adds xor, srl, sll and sltu, and adds iterative multiply and signed divide/remainder behind a Start/Busy/Done handshake. Single-cycle ops complete in one clock. Multiply and divide take a fixed multi-cycle latency, during which the core stalls on `Busy`.

## Interface
- `WIDTH`, 32, operand/result width (≥8, power of two)
- `SHW`, `$clog2(WIDTH)`, shift-amount bits taken from `SrcB` (derived, not overridden)
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `Start`  in  1  accept operation (sampled only when `Busy`=0)
- `SrcA`, `SrcB`  in  WIDTH  operands, signed unless the op says unsigned
- `ALUControl`  in  4  operation select
- `ALUResult`  out  WIDTH  registered result, held until the next accepted Start
- `Zero`  out  1  registered, (`ALUResult`==0)
- `Busy`  out  1  operation in flight
- `Done`  out  1  one-cycle pulse: `ALUResult`/`Zero` are valid

## Operation
- Opcodes:
  - 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor
  - 0101 slt (signed), 1001 sltu, with result 0 or 1 zero-extended
  - 0110 sra, 0111 srl, 1000 sll, with shift amount `SrcB[SHW-1:0]`
  - 1010 mul (low WIDTH bits), 1011 mulh (signed×signed, high WIDTH bits)
  - 1100 div (signed quotient), 1101 rem (signed remainder, sign of dividend)
  - 1110, 1111 → result 0, single-cycle
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE & Start & single-cycle op → DONE. The result is registered on that edge.
  - IDLE & Start & mul/mulh → MUL. Latch magnitudes, result sign, op, and clear a 2·WIDTH accumulator.
  - MUL: radix-2 shift-add, one multiplier bit per cycle for WIDTH cycles → DONE.
  - IDLE & Start & div/rem → DIV. Latch |SrcA| and |SrcB| plus signs; restoring division, one quotient bit per cycle for WIDTH cycles → DONE.
  - DONE: apply sign correction (two's complement of the 2·WIDTH product or of the quotient/remainder), write `ALUResult` and `Zero`, assert `Done` → IDLE.
- Arithmetic is all modulo 2^WIDTH; add/sub overflow is ignored.
- mulh sign: negate the 2·WIDTH product iff the operand signs differ.
- Divide by zero (RISC-V semantics):
  - quotient = all ones, remainder = SrcA.
  - Detected at Start; the DIV iterations still run so latency stays fixed.
- Overflow (SrcA = most-negative, SrcB = −1): quotient = most-negative, remainder = 0.
- Start while `Busy`=1 is ignored; operands and ALUControl are not re-sampled.
- Start in DONE is ignored (`Busy`=1 in DONE). Back-to-back issue is therefore every 2 cycles for single-cycle ops.

## Timing
- Reset values: `ALUResult`=0, `Zero`=1, `Busy`=0, `Done`=0, state IDLE, all datapath registers 0.
- Latency from the Start edge to `Done`:
  - single-cycle ops: 1 cycle
  - mul/mulh: WIDTH+1 cycles
  - div/rem: WIDTH+1 cycles
- `Busy` is high from the cycle after accepted Start up to and including the `Done` cycle.
- `Done` is high for exactly one cycle.
- `ALUResult`/`Zero` change only on the edge that raises `Done`, or on reset.
- Reset asserted mid-operation aborts immediately to reset values. No partial result is exposed.

## Configuration
- `ALU_SEQ_DIV_EN` defined: DIV state and divider datapath are present, as above.
- Not defined:
  - div/rem (1100, 1101) complete as single-cycle ops with result 0.
  - DIV state and divider registers are absent.
  - mul/mulh are unaffected.

## Structure
- Package `alu_seq_pkg`:
  - opcode localparams (`ALU_ADD` … `ALU_REM`)
  - FSM state enum typedef
  - `WIDTH` default constant
- The iterative divider is a natural sub-module, `alu_seq_div`:
  - inputs: start, magnitudes
  - outputs: quotient/remainder magnitudes, valid
  - compiled only under `ALU_SEQ_DIV_EN`
- Multiply stays inline.

## Test plan
- Reset: hold `rst_n`=0, pulse Start → `ALUResult`=0, `Zero`=1, `Busy`=0, `Done` never asserts.
- Single-cycle ops, WIDTH=32:
  - sub 5−5 → `ALUResult`=0, `Zero`=1, `Done` 1 cycle after Start
  - sra 0x80000000 by 4 → 0xF8000000
  - srl same → 0x08000000
  - sltu 1 vs 0xFFFFFFFF → 1; slt same → 0
- Multiply:
  - mul 0xFFFFFFFF×0xFFFFFFFF → 0x00000001
  - mulh same → 0x00000000
  - mulh 0x80000000×0x80000000 → 0x40000000
  - `Done` exactly 33 cycles after Start; `Busy` high throughout
- Divide (`ALU_SEQ_DIV_EN`):
  - div −7/2 → 0xFFFFFFFD; rem → 0xFFFFFFFF
  - div 9/0 → 0xFFFFFFFF; rem 9/0 → 9
  - div 0x80000000/−1 → 0x80000000; rem → 0
- Handshake: Start pulsed every cycle with changing operands during a mul → only the first op executes and the result matches it.
- Abort: deassert `rst_n` at cycle 10 of a div → outputs return to reset values asynchronously; a fresh add 2+3 then returns 5 after 1 cycle.
